spi_prog_loader: RTL and testbench

SPI slave front-end that loads and reads back the Post machine's program/tape memory from an external host. Sits directly upstream of the Post system core: it converts the raw pad-level SPI signals into a single-cycle memory write port and an address/read-data port, and returns read data on MISO. Active only in programming mode. All SPI inputs are asynchronous to CLK and are synchronized internally.

---
 rtl/spi_prog_loader.sv | 203 ++++++++++++++++++++
 tb/tb_spi_prog_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_prog_loader.sv
// SPI slave (mode 0) that loads and reads back the Post machine program/tape
// memory. Pad-level SCK/MOSI/CS are synchronized into CLK. Every frame is
// turned into single-cycle memory writes or address-sequenced reads.
module spi_prog_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              NRST,
   input  logic              MODE,
   input  logic              SPI_SCK,
   input  logic              SPI_MOSI,
   input  logic              SPI_CS,
   output logic              SPI_MISO,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   output logic              MEM_WE,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              BUSY,
   output logic              ERR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WDATA,
      S_RDATA,
      S_IGNORE
   } state_t;

   // synchronizer stages; *_dly_q is the extra copy used for edge detection
   logic sck_meta_q, sck_sync_q, sck_dly_q;
   logic mosi_meta_q, mosi_sync_q;
   logic cs_meta_q, cs_sync_q, cs_dly_q;

   state_t              state_q, state_d;
   logic [2:0]          bitcnt_q, bitcnt_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                reload_q, reload_d;   // next SCK fall loads tx from memory
   logic                load_q, load_d;       // first cycle in RDATA: preload tx
   logic                err_q, err_d;

   logic                sck_rise, sck_fall, cs_fall, byte_done;
   logic [DATA_W-1:0]   rx_byte;
   logic [ADDR_W-1:0]   cmd_addr;

   assign sck_rise  = sck_sync_q & ~sck_dly_q;
   assign sck_fall  = ~sck_sync_q & sck_dly_q;
   assign cs_fall   = ~cs_sync_q & cs_dly_q;
   assign rx_byte   = {shift_q[DATA_W-2:0], mosi_sync_q};
   assign byte_done = sck_rise && (bitcnt_q == 3'd7);
   assign cmd_addr  = ADDR_W'(rx_byte[3:0]);

   // Two-flop synchronizers for the asynchronous SPI pads, plus delayed copies.
   // CS resets low so a CS held low across reset never looks like a new frame.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         sck_meta_q  <= 1'b0;
         sck_sync_q  <= 1'b0;
         sck_dly_q   <= 1'b0;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
         cs_meta_q   <= 1'b0;
         cs_sync_q   <= 1'b0;
         cs_dly_q    <= 1'b0;
      end else begin
         sck_meta_q  <= SPI_SCK;
         sck_sync_q  <= sck_meta_q;
         sck_dly_q   <= sck_sync_q;
         mosi_meta_q <= SPI_MOSI;
         mosi_sync_q <= mosi_meta_q;
         cs_meta_q   <= SPI_CS;
         cs_sync_q   <= cs_meta_q;
         cs_dly_q    <= cs_sync_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state_q  <= S_IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         tx_q     <= '0;
         reload_q <= 1'b0;
         load_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         tx_q     <= tx_d;
         reload_q <= reload_d;
         load_q   <= load_d;
         err_q    <= err_d;
      end
   end

   // Frame decode: next state, byte assembly, address sequencing, tx shifter.
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      tx_d     = tx_q;
      reload_d = reload_q;
      load_d   = 1'b0;
      err_d    = err_q;

      // address advances the cycle after a write strobe that actually fired
      if (we_q && MODE) addr_d = addr_q + ADDR_W'(1);

      if (sck_rise && (state_q != S_IDLE)) begin
         shift_d  = rx_byte;
         bitcnt_d = bitcnt_q + 3'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (cs_fall && MODE) begin
               state_d  = S_CMD;
               err_d    = 1'b0;
               bitcnt_d = '0;
               shift_d  = '0;
            end
         end
         S_CMD: begin
            if (byte_done) begin
               if (rx_byte[6:4] != 3'b000) begin
                  state_d = S_IGNORE;
                  err_d   = 1'b1;
               end else begin
                  addr_d = cmd_addr;
                  if (rx_byte[7]) begin
                     state_d = S_WDATA;
                  end else begin
                     // the fall that closes the command byte reloads rather
                     // than shifts, so bit 7 is on MISO for the first data rise
                     state_d  = S_RDATA;
                     load_d   = 1'b1;
                     reload_d = 1'b1;
                  end
               end
            end
         end
         S_WDATA: begin
            if (byte_done) begin
               wdata_d = rx_byte;
               we_d    = 1'b1;
            end
         end
         S_RDATA: begin
            if (load_q) tx_d = MEM_RDATA;
            if (sck_fall) begin
               if (reload_q) begin
                  tx_d     = MEM_RDATA;
                  reload_d = 1'b0;
               end else begin
                  tx_d = {tx_q[DATA_W-2:0], 1'b0};
               end
            end
            if (byte_done) begin
               addr_d   = addr_q + ADDR_W'(1);
               reload_d = 1'b1;
            end
         end
         S_IGNORE: ;
         default: state_d = S_IDLE;
      endcase

      // CS high or run mode aborts everything, including a write decided
      // in this same cycle; the partial byte is dropped
      if (!MODE || cs_sync_q) begin
         state_d  = S_IDLE;
         bitcnt_d = '0;
         shift_d  = '0;
         we_d     = 1'b0;
         reload_d = 1'b0;
         load_d   = 1'b0;
         tx_d     = '0;
      end
   end

   assign MEM_ADDR  = addr_q;
   assign MEM_WDATA = wdata_q;
   assign MEM_WE    = we_q & MODE;   // MODE drop kills a pending strobe at once
   assign SPI_MISO  = (state_q == S_RDATA) ? tx_q[DATA_W-1] : 1'b0;
   assign BUSY      = (state_q != S_IDLE);
   assign ERR       = err_q;

endmodule

// File: tb/tb_spi_prog_loader.sv
// Directed bench for spi_prog_loader: bit-banged SPI host, behavioural
// memory, and a write log captured from the memory port.
module tb_spi_prog_loader;

   localparam int HALF = 6;   // SCK half period in CLK cycles

   logic       CLK = 1'b0;
   logic       NRST = 1'b0;
   logic       MODE = 1'b0;
   logic       SPI_SCK = 1'b0;
   logic       SPI_MOSI = 1'b0;
   logic       SPI_CS = 1'b1;
   logic       SPI_MISO;
   logic [3:0] MEM_ADDR;
   logic [7:0] MEM_WDATA;
   logic       MEM_WE;
   logic [7:0] MEM_RDATA;
   logic       BUSY;
   logic       ERR;

   logic [7:0] mem [16];
   logic [3:0] wr_addr [$];
   logic [7:0] wr_data [$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       saw_we;
   logic [7:0] rx, rx1, rx2;

   spi_prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
      .CLK       (CLK),
      .NRST      (NRST),
      .MODE      (MODE),
      .SPI_SCK   (SPI_SCK),
      .SPI_MOSI  (SPI_MOSI),
      .SPI_CS    (SPI_CS),
      .SPI_MISO  (SPI_MISO),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_WDATA (MEM_WDATA),
      .MEM_WE    (MEM_WE),
      .MEM_RDATA (MEM_RDATA),
      .BUSY      (BUSY),
      .ERR       (ERR)
   );

   always #5 CLK = ~CLK;

   assign MEM_RDATA = mem[MEM_ADDR];

   // log every strobed cycle and update the model memory
   always @(negedge CLK) begin
      if (MEM_WE === 1'b1) begin
         wr_addr.push_back(MEM_ADDR);
         wr_data.push_back(MEM_WDATA);
         mem[MEM_ADDR] <= MEM_WDATA;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // shift out the top n bits of tx; rx collects MISO sampled before each rise
   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
      r = '0;
      for (int i = 7; i > 7 - n; i--) begin
         SPI_MOSI = tx[i];
         clks(HALF);
         r = {r[6:0], SPI_MISO};
         SPI_SCK = 1'b1;
         clks(HALF);
         SPI_SCK = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
      spi_bits(tx, 8, r);
   endtask

   task automatic cs_low;
      SPI_CS = 1'b0;
      clks(HALF);
   endtask

   task automatic cs_high;
      clks(HALF);
      SPI_CS = 1'b1;
      clks(10);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;

      // reset state
      clks(3);
      check("rst_addr",  MEM_ADDR, 0);
      check("rst_wdata", MEM_WDATA, 0);
      check("rst_ctl",   {MEM_WE, SPI_MISO, BUSY, ERR}, 4'b0000);
      NRST = 1'b1;
      MODE = 1'b1;
      clks(5);

      // write burst 0x83, 0xA5, 0x3C
      cs_low();
      check("busy_frame", BUSY, 1);
      spi_byte(8'h83, rx);
      spi_byte(8'hA5, rx);
      spi_byte(8'h3C, rx);
      cs_high();
      check("wr_count",  wr_addr.size(), 2);
      if (wr_addr.size() >= 2) begin
         check("wr0", {wr_addr[0], wr_data[0]}, {4'h3, 8'hA5});
         check("wr1", {wr_addr[1], wr_data[1]}, {4'h4, 8'h3C});
      end
      check("wr_addr_end", MEM_ADDR, 5);
      check("wr_idle",     {BUSY, ERR}, 2'b00);

      // wrap write 0x8F, 0x11, 0x22
      cs_low();
      spi_byte(8'h8F, rx);
      spi_byte(8'h11, rx);
      spi_byte(8'h22, rx);
      cs_high();
      check("wrap_count", wr_addr.size(), 4);
      if (wr_addr.size() >= 4) begin
         check("wrap0", {wr_addr[2], wr_data[2]}, {4'hF, 8'h11});
         check("wrap1", {wr_addr[3], wr_data[3]}, {4'h0, 8'h22});
      end
      check("wrap_addr_end", MEM_ADDR, 1);

      // read burst from address 2
      mem[2] = 8'h5A;
      mem[3] = 8'hC3;
      cs_low();
      spi_byte(8'h02, rx);
      spi_byte(8'h00, rx1);
      spi_byte(8'h00, rx2);
      check("rd_busy", BUSY, 1);
      cs_high();
      check("rd_byte0",  rx1, 8'h5A);
      check("rd_byte1",  rx2, 8'hC3);
      check("rd_no_we",  wr_addr.size(), 4);
      check("rd_addr",   MEM_ADDR, 4);
      check("miso_idle", SPI_MISO, 0);

      // bad command sets ERR, no write
      cs_low();
      spi_byte(8'h93, rx);
      clks(4);
      check("bad_err", ERR, 1);
      spi_byte(8'hFF, rx);
      cs_high();
      check("bad_no_we",  wr_addr.size(), 4);
      check("bad_sticky", ERR, 1);

      // next good frame clears ERR at CS fall and writes (1, 0x77)
      cs_low();
      check("err_clear", ERR, 0);
      spi_byte(8'h81, rx);
      spi_byte(8'h77, rx);
      cs_high();
      check("ok_count", wr_addr.size(), 5);
      if (wr_addr.size() >= 5)
         check("ok_wr", {wr_addr[4], wr_data[4]}, {4'h1, 8'h77});

      // abort: CS high after 5 data bits
      cs_low();
      spi_byte(8'h85, rx);
      spi_bits(8'hFF, 5, rx);
      cs_high();
      check("abort_no_we", wr_addr.size(), 5);
      check("abort_busy",  BUSY, 0);

      // run mode mid-frame
      cs_low();
      spi_byte(8'h86, rx);
      spi_bits(8'hAA, 4, rx);
      MODE = 1'b0;
      clks(2);
      check("mode_busy", BUSY, 0);
      spi_bits(8'hAA, 4, rx);
      cs_high();
      check("mode_no_we", wr_addr.size(), 5);
      MODE = 1'b1;
      clks(4);

      // MODE drops in the very cycle the strobe goes out
      saw_we = 1'b0;
      cs_low();
      spi_byte(8'h8A, rx);
      fork
         spi_byte(8'h99, rx);
         begin
            for (int i = 0; i < 200; i++) begin
               @(posedge CLK);
               #1;
               if (MEM_WE === 1'b1) begin
                  MODE = 1'b0;
                  saw_we = 1'b1;
                  break;
               end
            end
         end
      join
      cs_high();
      check("sup_strobe", saw_we, 1);
      check("sup_no_we",  wr_addr.size(), 5);
      check("sup_mem",    mem[10], 8'h00);
      MODE = 1'b1;
      clks(4);

      // asynchronous reset mid-frame
      cs_low();
      spi_byte(8'h87, rx);
      spi_bits(8'h55, 3, rx);
      check("pre_rst_busy", BUSY, 1);
      NRST = 1'b0;
      #1;
      check("nrst_addr", MEM_ADDR, 0);
      check("nrst_ctl",  {MEM_WE, SPI_MISO, BUSY, ERR, MEM_WDATA}, 12'h000);
      clks(2);
      NRST = 1'b1;
      clks(HALF);
      check("post_rst_busy", BUSY, 0);
      SPI_CS = 1'b1;
      clks(10);
      check("post_rst_no_we", wr_addr.size(), 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
